// File: rtl/asteroid_spawner.sv
// ---------------------------------------------------------------------------
// asteroid_spawner
//
// Upstream controller for the asteroid mover. It decides when an asteroid
// launches, picks the asteroid's speed class and start column from a free
// running LFSR, and retires the asteroid once the offsets fed back from the
// mover leave the playfield. It also counts retired asteroids for the score
// display.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous reset, active low
//   halt         in   1   game paused/over; freezes every register
//   game_start   in   1   one-clock pulse; leaves IDLE and starts spawning
//   xmovaddr     in  10   x offset returned by the mover
//   ymovaddr     in  10   y offset returned by the mover
//   asteroid_on  out  1   asteroid active (to mover and renderer)
//   new_count    out  2   speed class 0..2, stable while asteroid_on = 1
//   spawn_x      out 10   start column, stable while asteroid_on = 1
//   spawn_total  out  8   retired asteroid count, saturates at 255
//   busy         out  1   high in every state except IDLE
// ---------------------------------------------------------------------------
module asteroid_spawner #(
  parameter int          TICK_DIV  = 251250,
  parameter int          MIN_GAP   = 64,
  parameter logic [7:0]  GAP_MASK  = 8'h3F,
  parameter logic [9:0]  X_LIMIT   = 10'd640,
  parameter logic [9:0]  Y_LIMIT   = 10'd480,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       game_start,
  input  logic [9:0] xmovaddr,
  input  logic [9:0] ymovaddr,
  output logic       asteroid_on,
  output logic [1:0] new_count,
  output logic [9:0] spawn_x,
  output logic [7:0] spawn_total,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, GAP, FLY, CLEAR} state_t;

  state_t          state, state_d;
  logic [15:0]     lfsr, lfsr_d, lfsr_step;
  logic [PW-1:0]   prescaler, prescaler_d;
  logic [8:0]      gap_cnt, gap_cnt_d;
  logic            clr_cnt, clr_cnt_d;
  logic            tick, at_limit;

  logic            asteroid_on_d;
  logic [1:0]      new_count_d;
  logic [9:0]      spawn_x_d;
  logic [7:0]      spawn_total_d;
  logic            busy_d;

  // Galois form, taps 16,14,13,11: shift right and fold the dropped bit
  // back in through the tap mask.
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // The prescaler only advances in GAP, so the tick is only meaningful there.
  assign tick     = (state == GAP) && (prescaler == PW'(TICK_DIV - 1));
  assign at_limit = (xmovaddr >= X_LIMIT) || (ymovaddr >= Y_LIMIT);

  // State and datapath registers; every output is registered here too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      prescaler   <= '0;
      gap_cnt     <= '0;
      clr_cnt     <= 1'b0;
      asteroid_on <= 1'b0;
      new_count   <= 2'd0;
      spawn_x     <= 10'd0;
      spawn_total <= 8'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      lfsr        <= lfsr_d;
      prescaler   <= prescaler_d;
      gap_cnt     <= gap_cnt_d;
      clr_cnt     <= clr_cnt_d;
      asteroid_on <= asteroid_on_d;
      new_count   <= new_count_d;
      spawn_x     <= spawn_x_d;
      spawn_total <= spawn_total_d;
      busy        <= busy_d;
    end
  end

  // Next-state logic. halt overrides everything, including game_start and
  // the playfield limit compare.
  always_comb begin
    state_d = state;
    if (!halt) begin
      case (state)
        IDLE:    if (game_start) state_d = GAP;
        GAP:     if (tick && (gap_cnt == 9'd1)) state_d = FLY;
        FLY:     if (at_limit) state_d = CLEAR;
        CLEAR:   if (clr_cnt) state_d = GAP;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values for counters and outputs. Entry actions key off a state
  // change so the launch parameters and the retire count are captured
  // exactly once per flight, using the LFSR value of the transition cycle.
  always_comb begin
    lfsr_d        = lfsr;
    prescaler_d   = prescaler;
    gap_cnt_d     = gap_cnt;
    clr_cnt_d     = clr_cnt;
    asteroid_on_d = asteroid_on;
    new_count_d   = new_count;
    spawn_x_d     = spawn_x;
    spawn_total_d = spawn_total;
    busy_d        = busy;

    if (!halt) begin
      lfsr_d = lfsr_step;

      if (state == GAP) begin
        prescaler_d = tick ? '0 : prescaler + 1'b1;
        if (tick) gap_cnt_d = gap_cnt - 9'd1;
      end

      // clr_cnt marks the second CLEAR clock.
      if (state == CLEAR) clr_cnt_d = 1'b1;

      if (state_d != state) begin
        case (state_d)
          GAP: begin
            prescaler_d = '0;
            gap_cnt_d   = 9'(MIN_GAP) + {1'b0, lfsr[7:0] & GAP_MASK};
          end
          FLY: begin
            asteroid_on_d = 1'b1;
            new_count_d   = (lfsr[1:0] == 2'd3) ? 2'd2 : lfsr[1:0];
            spawn_x_d     = {1'b0, lfsr[14:6]};
          end
          CLEAR: begin
            asteroid_on_d = 1'b0;
            clr_cnt_d     = 1'b0;
            spawn_total_d = (spawn_total == 8'hFF) ? spawn_total : spawn_total + 8'd1;
          end
          default: begin
          end
        endcase
      end

      busy_d = (state_d != IDLE);
    end
  end

endmodule
